// File: rtl/npu_row_streamer_if.sv
// Link between the host-side row streamer and the NPU row controller.
//   npu_start  : one-cycle row start pulse (streamer -> controller)
//   npu_data   : pixel byte (streamer -> controller)
//   npu_valid  : npu_data qualifier (streamer -> controller)
//   npu_done   : row done pulse (controller -> streamer)
//   npu_result : row result byte, valid with npu_done (controller -> streamer)
interface npu_row_streamer_if;
  logic       npu_start;
  logic [7:0] npu_data;
  logic       npu_valid;
  logic       npu_done;
  logic [7:0] npu_result;

  modport master (
    output npu_start, npu_data, npu_valid,
    input  npu_done, npu_result
  );

  modport slave (
    input  npu_start, npu_data, npu_valid,
    output npu_done, npu_result
  );
endinterface

// File: rtl/npu_row_streamer.sv
// Host-side sender for the NPU row controller. Holds a NUM_ROWS x ROW_LEN frame of pixel bytes;
// on run, each row gets a start pulse, its bytes streamed over data/valid (GAP idle cycles after
// each non-final byte), then a wait for the done pulse whose result byte is stored per row.
// A row with no answer within TIMEOUT cycles aborts the frame and sets the sticky timeout_err.
//   clk, rst      : clock, synchronous active-high reset
//   load_we/addr/data : frame-buffer write port (ignored while busy or out of range)
//   run           : one-cycle frame request (ignored while busy)
//   npu           : controller link (master side)
//   res_addr/data : combinational result read port
//   busy, frame_done, timeout_err : frame status (all registered)
module npu_row_streamer #(
  parameter int unsigned ROW_LEN  = 32,
  parameter int unsigned NUM_ROWS = 4,
  parameter int unsigned GAP      = 0,
  parameter int unsigned TIMEOUT  = 1024,
  localparam int unsigned AW = (NUM_ROWS * ROW_LEN > 1) ? $clog2(NUM_ROWS * ROW_LEN) : 1,
  localparam int unsigned RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_we,
  input  logic [AW-1:0]       load_addr,
  input  logic [7:0]          load_data,
  input  logic                run,
  npu_row_streamer_if.master  npu,
  input  logic [RW-1:0]       res_addr,
  output logic [7:0]          res_data,
  output logic                busy,
  output logic                frame_done,
  output logic                timeout_err
);

  localparam int unsigned BW    = (ROW_LEN > 1) ? $clog2(ROW_LEN) : 1;
  localparam int unsigned TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned DEPTH = NUM_ROWS * ROW_LEN;

  localparam logic [BW-1:0] LAST_BYTE = BW'(ROW_LEN - 1);
  localparam logic [RW-1:0] LAST_ROW  = RW'(NUM_ROWS - 1);
  localparam logic [3:0]    GAP_LAST  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StKick, StSend, StGap, StWait, StNext, StFin} state_e;

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] byte_q, byte_d;
  logic [3:0]    gap_q, gap_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
  logic          res_we;

  logic          start_q, start_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          fdone_q, fdone_d;
  logic [AW-1:0] rd_addr;

  logic [7:0]    frame_q  [DEPTH];
  logic [7:0]    result_q [NUM_ROWS];

  // Frame buffer: no reset, writes only while idle.
  always_ff @(posedge clk) begin
    if (load_we && !busy_q && (32'(load_addr) < DEPTH)) begin
      frame_q[load_addr] <= load_data;
    end
  end

  // State register, counters, result buffer and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      row_q   <= '0;
      byte_q  <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      fdone_q <= 1'b0;
      for (int i = 0; i < NUM_ROWS; i++) result_q[i] <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      byte_q  <= byte_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      start_q <= start_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      fdone_q <= fdone_d;
      if (res_we) result_q[row_q] <= npu.npu_result;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    byte_d  = byte_q;
    gap_d   = gap_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    res_we  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (run) begin
          state_d = StKick;
          row_d   = '0;
          err_d   = 1'b0;
        end
      end
      StKick: begin
        byte_d  = '0;
        state_d = StSend;
      end
      StSend: begin
        if (byte_q == LAST_BYTE) begin
          state_d = StWait;
          tmo_d   = '0;
        end else if (GAP > 0) begin
          state_d = StGap;
          gap_d   = '0;
        end else begin
          byte_d  = byte_q + 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GAP_LAST) begin
          state_d = StSend;
          byte_d  = byte_q + 1'b1;
        end else begin
          gap_d   = gap_q + 1'b1;
        end
      end
      StWait: begin
        // A done arriving on the last allowed cycle still wins over the abort.
        if (npu.npu_done) begin
          res_we  = 1'b1;
          state_d = StNext;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
      end
      StNext: begin
        if (row_q == LAST_ROW) begin
          state_d = StFin;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = StKick;
        end
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output next-values are decoded from the next state so every output comes straight off a flop.
  always_comb begin
    rd_addr = AW'(32'(row_d) * ROW_LEN + 32'(byte_d));
    start_d = (state_d == StKick);
    valid_d = (state_d == StSend);
    data_d  = valid_d ? frame_q[rd_addr] : 8'h00;
    busy_d  = (state_d != StIdle);
    fdone_d = (state_d == StFin);
  end

  always_comb begin
    res_data = 8'h00;
    if (32'(res_addr) < NUM_ROWS) res_data = result_q[res_addr];
  end

  assign npu.npu_start = start_q;
  assign npu.npu_valid = valid_q;
  assign npu.npu_data  = data_q;
  assign busy          = busy_q;
  assign frame_done    = fdone_q;
  assign timeout_err   = err_q;

endmodule
